// File: rtl/tilt_alarm_monitor.sv
// Tilt alarm monitor: scales raw accelerometer samples to tenths of a degree,
// drives a center-split LED bar and a debounced SAFE/WARN/CRIT alarm with buzzer.
module tilt_alarm_monitor #(
  parameter int NUM_AXES    = 2,
  parameter int DATA_W      = 16,
  parameter int SCALE_NUM   = 900,
  parameter int SCALE_SHIFT = 8,
  parameter int ANGLE_MAX   = 900,
  parameter int WARN_TH     = 600,
  parameter int CRIT_TH     = 800,
  parameter int HYST        = 50,
  parameter int DEBOUNCE    = 3,
  parameter int LED_W       = 10,
  parameter int LED_STEP    = 160,
  parameter int BEEP_HALF   = 12_500_000
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            sample_valid,
  input  logic [NUM_AXES*DATA_W-1:0]                      sample_data,
  input  logic [((NUM_AXES > 1) ? $clog2(NUM_AXES) : 1)-1:0] axis_sel,
  input  logic                                            freeze,
  input  logic                                            mute,
  output logic signed [11:0]                              angle,
  output logic                                            angle_valid,
  output logic [LED_W-1:0]                                led_bar,
  output logic [1:0]                                      alarm_state,
  output logic                                            buzzer
);

  localparam int AXIS_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int PW     = DATA_W + 11;
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int BC_W   = $clog2(4 * BEEP_HALF + 1);

  localparam logic signed [PW-1:0] SCALE_S = PW'(SCALE_NUM);
  localparam logic signed [PW-1:0] RND     = PW'((1 << SCALE_SHIFT) - 1);
  localparam logic signed [PW-1:0] AMAX    = PW'(ANGLE_MAX);
  localparam logic [11:0] WARN_T  = 12'(WARN_TH);
  localparam logic [11:0] CRIT_T  = 12'(CRIT_TH);
  localparam logic [11:0] WARN_LO = 12'(WARN_TH - HYST);
  localparam logic [11:0] CRIT_LO = 12'(CRIT_TH - HYST);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [BC_W-1:0] HALF_CRIT = BC_W'(BEEP_HALF - 1);
  localparam logic [BC_W-1:0] HALF_WARN = BC_W'(4 * BEEP_HALF - 1);

  typedef enum logic [1:0] {SAFE = 2'd0, WARN = 2'd1, CRIT = 2'd2} state_t;

  // Negative products get a bias before the arithmetic shift so the divide truncates toward zero.
  function automatic logic signed [11:0] axis_angle(input logic signed [DATA_W-1:0] s);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] quot;
    prod = PW'(s) * SCALE_S;
    quot = prod[PW-1] ? ((prod + RND) >>> SCALE_SHIFT) : (prod >>> SCALE_SHIFT);
    if (quot > AMAX) quot = AMAX;
    else if (quot < -AMAX) quot = -AMAX;
    return quot[11:0];
  endfunction

  function automatic state_t level(input logic [11:0] m);
    if (m >= CRIT_T) return CRIT;
    if (m >= WARN_T) return WARN;
    return SAFE;
  endfunction

  logic signed [11:0] ang_c [NUM_AXES];
  logic [11:0]        abs_c [NUM_AXES];
  logic signed [11:0] sel_ang;
  logic [11:0]        sel_abs;
  logic [11:0]        mag_c;
  logic [LED_W-1:0]   led_c;
  logic               accept;
  logic [11:0]        mag_q;

  assign accept = sample_valid && !freeze;

  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      ang_c[i] = axis_angle(sample_data[i*DATA_W +: DATA_W]);
      abs_c[i] = ang_c[i][11] ? 12'(-ang_c[i]) : ang_c[i];
    end
  end

  always_comb begin
    sel_ang = ang_c[0];
    mag_c   = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (abs_c[i] > mag_c) mag_c = abs_c[i];
      if (axis_sel == AXIS_W'(i)) sel_ang = ang_c[i];
    end
  end

  always_comb begin
    sel_abs = sel_ang[11] ? 12'(-sel_ang) : sel_ang;
    led_c   = '0;
    for (int k = 1; k <= LED_W / 2; k++) begin
      if (32'(sel_abs) >= 32'(k * LED_STEP)) begin
        if (!sel_ang[11]) led_c[LED_W/2-1+k] = 1'b1;
        else              led_c[LED_W/2-k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      angle       <= '0;
      angle_valid <= 1'b0;
      led_bar     <= '0;
      mag_q       <= '0;
    end else begin
      angle_valid <= accept;
      if (accept) begin
        angle   <= sel_ang;
        led_bar <= led_c;
        mag_q   <= mag_c;
      end
    end
  end

  // Alarm FSM: evaluates the registered magnitude one cycle after each accepted sample.
  state_t          state;
  state_t          lvl;
  state_t          up_lvl;
  state_t          up_lvl_n;
  logic [DB_W-1:0] up_cnt;
  logic [DB_W-1:0] dn_cnt;
  logic [BC_W-1:0] beep_cnt;
  logic [BC_W-1:0] half;
  logic [11:0]     thr_lo;
  logic            up_qual, dn_qual, up_fire, dn_fire, mute_q;

  always_comb begin
    lvl      = level(mag_q);
    thr_lo   = (state == CRIT) ? CRIT_LO : WARN_LO;
    up_qual  = angle_valid && (lvl > state);
    dn_qual  = angle_valid && (state != SAFE) && (mag_q < thr_lo);
    up_lvl_n = ((up_cnt == '0) || (lvl < up_lvl)) ? lvl : up_lvl;
    up_fire  = up_qual && (up_cnt == DB_LAST);
    dn_fire  = dn_qual && (dn_cnt == DB_LAST);
    half     = (state == CRIT) ? HALF_CRIT : HALF_WARN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SAFE;
      up_lvl   <= SAFE;
      up_cnt   <= '0;
      dn_cnt   <= '0;
      beep_cnt <= '0;
      buzzer   <= 1'b0;
      mute_q   <= 1'b0;
    end else begin
      if (angle_valid) begin
        up_cnt <= up_qual ? up_cnt + 1'b1 : '0;
        dn_cnt <= dn_qual ? dn_cnt + 1'b1 : '0;
        up_lvl <= up_lvl_n;
      end
      if (up_fire || dn_fire) begin
        state    <= up_fire ? up_lvl_n : lvl;
        up_cnt   <= '0;
        dn_cnt   <= '0;
        beep_cnt <= '0;
        buzzer   <= 1'b0;
        mute_q   <= 1'b0;
      end else if (state == SAFE) begin
        beep_cnt <= '0;
        buzzer   <= 1'b0;
        mute_q   <= 1'b0;
      end else if (mute || mute_q) begin
        mute_q   <= 1'b1;
        beep_cnt <= '0;
        buzzer   <= 1'b0;
      end else if (beep_cnt == half) begin
        beep_cnt <= '0;
        buzzer   <= ~buzzer;
      end else begin
        beep_cnt <= beep_cnt + 1'b1;
      end
    end
  end

  assign alarm_state = state;

endmodule
